// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: runtime divisor into an oversample tick, then an xmit tick.
// Optional fractional divide (eighths) when UART_BAUD_FRAC_EN is defined.
module uart_baud_gen #(
    parameter int BAUD_W     = 13,
    parameter int OVERSAMPLE = 16,
    parameter int OS_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              restart,
    input  logic [BAUD_W-1:0] baud_val,
    input  logic [2:0]        baud_frac,
    output logic              baud_tick,
    output logic              xmit_tick,
    output logic [OS_W-1:0]   os_phase
);

    // One extra bit so baud_val plus a fractional carry cannot overflow.
    logic [BAUD_W:0]   cnt;
    logic [OS_W-1:0]   os_cnt;
    logic [BAUD_W:0]   reload;
    logic              clear;
    logic              at_reload;
    logic              os_wrap;

    assign clear     = reset | restart | ~en;
    assign at_reload = (cnt == '0);
    assign os_wrap   = (os_cnt == OS_W'(OVERSAMPLE - 1));

`ifdef UART_BAUD_FRAC_EN
    logic [2:0] frac_acc;
    logic [3:0] frac_sum;

    assign frac_sum = {1'b0, frac_acc} + {1'b0, baud_frac};
    assign reload   = {1'b0, baud_val} + {{BAUD_W{1'b0}}, frac_sum[3]};

    always_ff @(posedge clk) begin
        if (clear) begin
            frac_acc <= '0;
        end else if (at_reload) begin
            frac_acc <= frac_sum[2:0];
        end
    end
`else
    logic unused_frac;

    assign unused_frac = ^baud_frac;
    assign reload      = {1'b0, baud_val};
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt       <= '0;
            os_cnt    <= '0;
            baud_tick <= 1'b0;
            xmit_tick <= 1'b0;
        end else if (at_reload) begin
            cnt       <= reload;
            baud_tick <= 1'b1;
            xmit_tick <= os_wrap;
            os_cnt    <= os_wrap ? '0 : os_cnt + 1'b1;
        end else begin
            cnt       <= cnt - 1'b1;
            baud_tick <= 1'b0;
            xmit_tick <= 1'b0;
        end
    end

    assign os_phase = os_cnt;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: expected tick schedules are queued per cycle and
// popped against the DUT outputs sampled 1 time unit after each rising edge.
module tb_uart_baud_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic        restart;
    logic [12:0] baud_val;
    logic [2:0]  baud_frac;
    logic        baud_tick;
    logic        xmit_tick;
    logic [3:0]  os_phase;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        int         n;
        logic       bt;
        logic       xt;
        logic [3:0] ph;
    } exp_t;

    exp_t sbq[$];
    int   tq[$];

    uart_baud_gen #(.BAUD_W(13), .OVERSAMPLE(16), .OS_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .restart   (restart),
        .baud_val  (baud_val),
        .baud_frac (baud_frac),
        .baud_tick (baud_tick),
        .xmit_tick (xmit_tick),
        .os_phase  (os_phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string tag, input int n, input logic bt,
                            input logic xt, input logic [3:0] ph);
        exp_t e;
        e.tag = tag;
        e.n   = n;
        e.bt  = bt;
        e.xt  = xt;
        e.ph  = ph;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop();
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty got=%0d exp=1", sbq.size());
            return;
        end
        e = sbq.pop_front();
        total++;
        assert (baud_tick === e.bt) else begin
            bad++;
            $error("FAIL %s baud_tick n=%0d got=%b exp=%b", e.tag, e.n, baud_tick, e.bt);
        end
        total++;
        assert (xmit_tick === e.xt) else begin
            bad++;
            $error("FAIL %s xmit_tick n=%0d got=%b exp=%b", e.tag, e.n, xmit_tick, e.xt);
        end
        total++;
        assert (os_phase === e.ph) else begin
            bad++;
            $error("FAIL %s os_phase n=%0d got=%0d exp=%0d", e.tag, e.n, os_phase, e.ph);
        end
    endtask

    task automatic zero_step(input string tag);
        push_exp(tag, 0, 1'b0, 1'b0, 4'd0);
        step();
        check_pop();
    endtask

    // Cycle n counts edges since the generator started from a cleared state; tq lists the
    // cycles on which baud_tick must be visible.
    task automatic run_seg(input string tag, input int first, input int last);
        for (int n = first; n <= last; n++) begin
            int   c;
            logic bt;
            c  = 0;
            bt = 1'b0;
            foreach (tq[i]) begin
                if (tq[i] <= n) c++;
                if (tq[i] == n) bt = 1'b1;
            end
            push_exp(tag, n, bt, bt && (c % 16 == 0), 4'(c % 16));
            step();
            check_pop();
        end
    endtask

    task automatic build_even(input int period, input int count);
        tq.delete();
        for (int k = 0; k < count; k++) tq.push_back(1 + k * period);
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b1;
        restart   = 1'b0;
        baud_val  = 13'd3;
        baud_frac = 3'd0;

        zero_step("reset");
        zero_step("reset");
        zero_step("reset");

        reset = 1'b0;
        build_even(4, 40);
        run_seg("div4", 1, 130);

        en = 1'b0;
        zero_step("en_off");
        baud_val = 13'd0;
        en       = 1'b1;
        build_even(1, 60);
        run_seg("div1", 1, 40);

        en = 1'b0;
        zero_step("en_off");
        baud_val = 13'd3;
        en       = 1'b1;
        tq.delete();
        tq = '{1, 5, 9, 13, 23, 33, 43};
        run_seg("midchg", 1, 10);
        baud_val = 13'd9;
        run_seg("midchg", 11, 45);

        en = 1'b0;
        zero_step("en_off");
        baud_val = 13'd3;
        en       = 1'b1;
        build_even(4, 40);
        run_seg("pre_restart", 1, 26);
        restart = 1'b1;
        zero_step("restart");
        restart = 1'b0;
        run_seg("post_restart", 1, 20);

        reset   = 1'b1;
        restart = 1'b1;
        zero_step("reset_hold");
        zero_step("reset_hold");
        zero_step("reset_hold");
        reset = 1'b0;
        zero_step("restart_after_reset");
        restart = 1'b0;
        run_seg("post_reset", 1, 70);

        en = 1'b0;
        zero_step("en_off");
        baud_frac = 3'd4;
        en        = 1'b1;
`ifdef UART_BAUD_FRAC_EN
        tq.delete();
        tq.push_back(1);
        for (int k = 1; k < 20; k++) tq.push_back(tq[k-1] + ((k % 2 == 1) ? 4 : 5));
`else
        build_even(4, 40);
`endif
        run_seg("frac", 1, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
